mem_stage_ctrl: RTL and testbench

//  MEM stage of the LEGv8 pipeline. Produces the MEM/WB bundle (rd_data, ALU_result, MemtoReg)

---
 rtl/mem_stage_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// LEGv8 MEM stage: drives LDUR/STUR over a req/ack data bus and emits the MEM/WB bundle.
// An aligned memory op parks in BUSY until the ack or a timeout. Faulting accesses complete with RegWrite=0.
module mem_stage_ctrl #(
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_ALU_result,
    input  logic [DATA_W-1:0] in_write_data,
    input  logic              in_MemRead,
    input  logic              in_MemWrite,
    input  logic              in_MemtoReg,
    input  logic              in_RegWrite,
    input  logic [4:0]        in_Rd,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] ALU_result,
    output logic              MemtoReg,
    output logic              RegWrite,
    output logic [4:0]        WriteReg,
    output logic              wb_valid,
    output logic              stall,
    output logic              fault,
    output logic [1:0]        fault_code
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, next_state;

    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] lat_alu;
    logic              lat_read, lat_memtoreg, lat_regwrite;
    logic [4:0]        lat_rd;

    logic memop, conflict, misaligned, accept, timeout_hit;

    assign memop      = in_MemRead | in_MemWrite;
    assign conflict   = in_MemRead & in_MemWrite;
    assign misaligned = |in_ALU_result[2:0];

    always_comb begin
        next_state  = state;
        stall       = 1'b0;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && memop && !conflict && !misaligned) begin
                    stall      = 1'b1;
                    accept     = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    next_state = IDLE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    // Releasing stall here lets upstream advance as the aborted op retires.
                    timeout_hit = 1'b1;
                    next_state  = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            rd_data      <= '0;
            ALU_result   <= '0;
            MemtoReg     <= 1'b0;
            RegWrite     <= 1'b0;
            WriteReg     <= '0;
            wb_valid     <= 1'b0;
            fault        <= 1'b0;
            fault_code   <= 2'b00;
            lat_alu      <= '0;
            lat_read     <= 1'b0;
            lat_memtoreg <= 1'b0;
            lat_regwrite <= 1'b0;
            lat_rd       <= '0;
        end else begin
            wb_valid   <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
            RegWrite   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_alu      <= in_ALU_result;
                        lat_read     <= in_MemRead;
                        lat_memtoreg <= in_MemtoReg;
                        lat_regwrite <= in_RegWrite;
                        lat_rd       <= in_Rd;
                        dmem_req     <= 1'b1;
                        dmem_we      <= in_MemWrite;
                        dmem_addr    <= in_ALU_result;
                        dmem_wdata   <= in_write_data;
                        cnt          <= '0;
                    end else if (in_valid) begin
                        rd_data    <= '0;
                        ALU_result <= in_ALU_result;
                        MemtoReg   <= in_MemtoReg;
                        WriteReg   <= in_Rd;
                        wb_valid   <= 1'b1;
                        if (!memop) begin
                            RegWrite <= in_RegWrite;
                        end else begin
                            fault      <= 1'b1;
                            fault_code <= conflict ? 2'b11 : 2'b01;
                        end
                    end
                end
                BUSY: begin
                    if (dmem_ack || timeout_hit) begin
                        dmem_req   <= 1'b0;
                        cnt        <= '0;
                        ALU_result <= lat_alu;
                        MemtoReg   <= lat_memtoreg;
                        WriteReg   <= lat_rd;
                        wb_valid   <= 1'b1;
                        if (dmem_ack) begin
                            rd_data  <= lat_read ? dmem_rdata : '0;
                            RegWrite <= lat_regwrite;
                        end else begin
                            rd_data    <= '0;
                            fault      <= 1'b1;
                            fault_code <= 2'b10;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed LEGv8 cases, random instruction stream with a
// bus responder of chosen latency, and a scoreboard monitor on the MEM/WB bundle.
module tb_mem_stage_ctrl;
    localparam int W       = 64;
    localparam int TIMEOUT = 16;
    localparam int EW      = 64 + 64 + 1 + 1 + 5 + 1 + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_ALU_result = '0;
    logic [W-1:0]  in_write_data = '0;
    logic          in_MemRead = 1'b0;
    logic          in_MemWrite = 1'b0;
    logic          in_MemtoReg = 1'b0;
    logic          in_RegWrite = 1'b0;
    logic [4:0]    in_Rd = '0;
    logic          dmem_req, dmem_we;
    logic [W-1:0]  dmem_addr, dmem_wdata;
    logic          dmem_ack = 1'b0;
    logic [W-1:0]  dmem_rdata = '0;
    logic [W-1:0]  rd_data, ALU_result;
    logic          MemtoReg, RegWrite, wb_valid, stall, fault;
    logic [4:0]    WriteReg;
    logic [1:0]    fault_code;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    mem_stage_ctrl #(.DATA_W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ALU_result(in_ALU_result),
        .in_write_data(in_write_data), .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite),
        .in_MemtoReg(in_MemtoReg), .in_RegWrite(in_RegWrite), .in_Rd(in_Rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .rd_data(rd_data), .ALU_result(ALU_result),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .WriteReg(WriteReg), .wb_valid(wb_valid),
        .stall(stall), .fault(fault), .fault_code(fault_code)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req"}, dmem_req, 0);
        chk({tag, "_we"}, dmem_we, 0);
        chk({tag, "_addr"}, dmem_addr, 0);
        chk({tag, "_wdata"}, dmem_wdata, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_alu"}, ALU_result, 0);
        chk({tag, "_memtoreg"}, MemtoReg, 0);
        chk({tag, "_regwrite"}, RegWrite, 0);
        chk({tag, "_writereg"}, WriteReg, 0);
        chk({tag, "_wb_valid"}, wb_valid, 0);
        chk({tag, "_fault"}, fault, 0);
        chk({tag, "_fault_code"}, fault_code, 0);
    endtask

    // Reference model + driver: one instruction from EX/MEM, plus the bus responder for it.
    // lat = BUSY cycle index carrying the ack; lat >= TIMEOUT means the bus never answers.
    task automatic issue(input logic v, input logic mr, input logic mw, input logic [63:0] alu,
                         input logic [63:0] wd, input logic mtr, input logic rw,
                         input logic [4:0] rd, input int lat, input logic [63:0] rdat);
        logic ok;
        in_valid      = v;
        in_MemRead    = mr;
        in_MemWrite   = mw;
        in_ALU_result = alu;
        in_write_data = wd;
        in_MemtoReg   = mtr;
        in_RegWrite   = rw;
        in_Rd         = rd;
        if (!v) begin
            dmem_ack = 1'($urandom_range(0, 1));
            #1 chk("bubble_stall", stall, 0);
            cycle();
            dmem_ack = 1'b0;
        end else if (!(mr || mw)) begin
            exp_q.push_back({64'd0, alu, mtr, rw, rd, 1'b0, 2'b00});
            #1 chk("alu_stall", stall, 0);
            cycle();
        end else if (mr && mw) begin
            exp_q.push_back({64'd0, alu, mtr, 1'b0, rd, 1'b1, 2'b11});
            #1 chk("conflict_stall", stall, 0);
            chk("conflict_noreq", dmem_req, 0);
            cycle();
            chk("conflict_noreq_after", dmem_req, 0);
        end else if (alu % 8 != 0) begin
            exp_q.push_back({64'd0, alu, mtr, 1'b0, rd, 1'b1, 2'b01});
            #1 chk("misalign_stall", stall, 0);
            chk("misalign_noreq", dmem_req, 0);
            cycle();
            chk("misalign_noreq_after", dmem_req, 0);
        end else begin
            ok = (lat < TIMEOUT);
            exp_q.push_back({(ok && mr) ? rdat : 64'd0, alu, mtr, ok ? rw : 1'b0, rd,
                             !ok, ok ? 2'b00 : 2'b10});
            #1 chk("accept_stall", stall, 1);
            chk("accept_noreq_yet", dmem_req, 0);
            cycle();
            for (int c = 0; c < TIMEOUT; c++) begin
                chk("busy_req", dmem_req, 1);
                chk("busy_we", dmem_we, mw);
                chk("busy_addr", dmem_addr, alu);
                chk("busy_wdata", dmem_wdata, wd);
                if (c == lat) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdat;
                    #1 chk("ack_stall", stall, 0);
                    cycle();
                    dmem_ack   = 1'b0;
                    dmem_rdata = {$urandom, $urandom};
                    break;
                end else if (c == TIMEOUT - 1) begin
                    #1 chk("timeout_stall", stall, 0);
                    cycle();
                    break;
                end else begin
                    #1 chk("busy_stall", stall, 1);
                    cycle();
                end
            end
            chk("req_dropped", dmem_req, 0);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst_n) begin
            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wb: got wb_valid 1 expected no completion at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_rd_data", rd_data, e[137:74]);
                    chk("wb_alu", ALU_result, e[73:10]);
                    chk("wb_memtoreg", MemtoReg, 64'(e[9]));
                    chk("wb_regwrite", RegWrite, 64'(e[8]));
                    chk("wb_writereg", WriteReg, 64'(e[7:3]));
                    chk("wb_fault", fault, 64'(e[2]));
                    chk("wb_fault_code", fault_code, 64'(e[1:0]));
                end
            end else begin
                chk("idle_regwrite", RegWrite, 0);
                chk("idle_fault", fault, 0);
            end
        end
    end

    initial begin
        logic [63:0] a;
        int kind;
        dmem_rdata = 64'h1234_5678_9ABC_DEF0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        chk("reset_stall", stall, 0);
        rst_n = 1'b1;
        cycle();

        // directed
        issue(1, 0, 0, 64'h2A, 0, 0, 1, 5'd1, 0, 0);
        issue(1, 1, 0, 64'h100, 0, 1, 1, 5'd9, 2, 64'hDEADBEEF);
        issue(1, 0, 1, 64'h108, 64'h55, 0, 0, 5'd3, 0, 64'hFFFF);
        issue(1, 1, 0, 64'h103, 0, 1, 1, 5'd4, 0, 0);
        issue(1, 1, 1, 64'h200, 0, 1, 1, 5'd5, 0, 0);
        issue(1, 1, 0, 64'h300, 0, 1, 1, 5'd6, 99, 64'hAAAA);
        issue(1, 1, 0, 64'h308, 0, 1, 1, 5'd7, TIMEOUT - 1, 64'hBBBB);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // random stream
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 9);
            a = {$urandom, $urandom};
            if (kind >= 4 && kind <= 7) a[2:0] = 3'b000;
            if (kind == 8) a[2:0] = 3'($urandom_range(1, 7));
            case (kind)
                0:       issue(0, 0, 0, a, 0, 0, 0, 0, 0, 0);
                1, 2, 3: issue(1, 0, 0, a, {$urandom, $urandom}, 1'($urandom), 1'($urandom),
                               5'($urandom), 0, 0);
                4, 5:    issue(1, 1, 0, a, 0, 1'($urandom), 1'($urandom), 5'($urandom),
                               $urandom_range(0, TIMEOUT + 2), {$urandom, $urandom});
                6, 7:    issue(1, 0, 1, a, {$urandom, $urandom}, 1'($urandom), 1'($urandom),
                               5'($urandom), $urandom_range(0, TIMEOUT + 2), {$urandom, $urandom});
                8:       issue(1, $urandom_range(0, 1) == 1, 1'b1, a, 0, 1'($urandom), 1'($urandom),
                               5'($urandom), 0, 0);
                default: issue(1, 1, 1, a, 0, 1'($urandom), 1'($urandom), 5'($urandom), 0, 0);
            endcase
        end
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("queue_drained", 64'(exp_q.size()), 0);

        // reset on the 2nd BUSY cycle
        in_valid = 1'b1; in_MemRead = 1'b1; in_MemWrite = 1'b0;
        in_ALU_result = 64'h400; in_RegWrite = 1'b1; in_MemtoReg = 1'b1; in_Rd = 5'd12;
        #1 chk("rst_accept_stall", stall, 1);
        cycle();
        chk("rst_busy1_req", dmem_req, 1);
        cycle();
        chk("rst_busy2_req", dmem_req, 1);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1 check_all_zero("midbusy_reset");
        chk("midbusy_reset_stall", stall, 0);
        cycle();
        exp_q.delete();
        rst_n = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 64'hCAFE;
        cycle();
        dmem_ack = 1'b0;
        chk("stray_ack_wb", wb_valid, 0);
        chk("stray_ack_req", dmem_req, 0);
        cycle();
        chk("stray_ack_wb_later", wb_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
